// File: rtl/mul64_issue_retire.sv
// mul64_issue_retire
//   Issue/retire wrapper around a combinational 64x64 radix-4 Booth multiplier.
//   A request is taken under a valid/ready handshake, and the multiplier inputs
//   are then held stable for MUL_CYCLES cycles. The 128-bit product is captured
//   and the RISC-V style half is selected from it. A MULHSU with a negative a
//   gets a one-cycle correction step. The result is returned under a
//   valid/ready handshake.
//
// Optional feature (macro MUL64_ZERO_BYPASS_EN):
//   When the macro is defined, a request with a zero operand skips the
//   multicycle window and goes straight to DONE with a zero product.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    request valid
//   in_ready    request accepted this cycle if in_valid (IDLE only)
//   in_op       00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   in_a        operand a (multiplicand)
//   in_b        operand b (multiplier)
//   out_valid   result valid
//   out_ready   downstream accepts result
//   out_result  selected 64-bit result
//
// Parameters:
//   MUL_CYCLES  cycles allotted to the multiplier path, 1..15

// Combinational 64x64 multiplier. It uses radix-4 Booth recoding into 33
// partial products, and synthesis builds the summation tree.
// signedFlag=1 treats both operands as two's complement; otherwise both are
// treated as unsigned.
module Radix4BoothWallace64 (
   input  logic         signedFlag,
   input  logic [63:0]  multiplicand,
   input  logic [63:0]  multiplier,
   output logic [127:0] out
);
   logic [66:0]  y_ext;
   logic [127:0] mc;
   logic [127:0] pp;
   logic [127:0] acc;
   logic [2:0]   grp;

   always_comb begin
      // The multiplier is extended to 66 bits so that the top Booth digit
      // sees the correct sign (or zero) bits. A zero is appended below for y[-1].
      y_ext = signedFlag ? {{2{multiplier[63]}}, multiplier, 1'b0}
                         : {2'b00, multiplier, 1'b0};
      mc    = signedFlag ? {{64{multiplicand[63]}}, multiplicand}
                         : {64'd0, multiplicand};
      acc   = '0;
      pp    = '0;
      grp   = '0;
      for (int i = 0; i < 33; i++) begin
         grp = y_ext[2*i +: 3];
         case (grp)
            3'b001, 3'b010: pp = mc;
            3'b011:         pp = mc << 1;
            3'b100:         pp = -(mc << 1);
            3'b101, 3'b110: pp = -mc;
            default:        pp = '0;
         endcase
         acc = acc + (pp << (2*i));
      end
      out = acc;
   end
endmodule

// State table
//   state | meaning
//   IDLE  | ready for a request; in_ready=1
//   CALC  | multiplier inputs held; counting down the multicycle window
//   FIX   | MULHSU with negative a: subtract b from the high half
//   DONE  | result presented; waiting for out_ready
module mul64_issue_retire #(
   parameter int MUL_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_op,
   input  logic [63:0] in_a,
   input  logic [63:0] in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_result
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;

   localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

   logic [1:0]   state_q;
   logic [3:0]   cnt_q;
   logic [63:0]  a_q;
   logic [63:0]  b_q;
   logic [1:0]   op_q;
   logic         sf_q;
   logic [127:0] prod_q;
   logic         out_valid_q;
   logic [63:0]  out_result_q;

   logic [127:0] mul_out;
   logic [63:0]  fix_hi;

   Radix4BoothWallace64 u_mul (
      .signedFlag   (sf_q),
      .multiplicand (a_q),
      .multiplier   (b_q),
      .out          (mul_out)
   );

   // The unsigned product of a signed a and an unsigned b is too large by
   // b*2^64 when a is negative. Subtracting b from the high half corrects it.
   assign fix_hi = prod_q[127:64] - b_q;

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         sf_q         <= 1'b0;
         prod_q       <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q  <= in_a;
                  b_q  <= in_b;
                  op_q <= in_op;
                  sf_q <= (in_op == OP_MULH);
`ifdef MUL64_ZERO_BYPASS_EN
                  if ((in_a == 64'd0) || (in_b == 64'd0)) begin
                     prod_q       <= '0;
                     out_result_q <= '0;
                     out_valid_q  <= 1'b1;
                     state_q      <= DONE;
                  end else begin
                     cnt_q   <= CNT_LOAD;
                     state_q <= CALC;
                  end
`else
                  cnt_q   <= CNT_LOAD;
                  state_q <= CALC;
`endif
               end
            end
            CALC: begin
               if (cnt_q == 4'd0) begin
                  prod_q <= mul_out;
                  if ((op_q == OP_MULHSU) && a_q[63]) begin
                     state_q <= FIX;
                  end else begin
                     out_result_q <= (op_q == OP_MUL) ? mul_out[63:0] : mul_out[127:64];
                     out_valid_q  <= 1'b1;
                     state_q      <= DONE;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            FIX: begin
               prod_q[127:64] <= fix_hi;
               out_result_q   <= fix_hi;
               out_valid_q    <= 1'b1;
               state_q        <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mul64_issue_retire.sv
module tb_mul64_issue_retire;
   localparam int MUL_CYCLES = 2;
   localparam int TIMEOUT    = 60;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_result;

   int vectors = 0;
   int fails   = 0;

   logic [63:0] sb[$];

   mul64_issue_retire #(.MUL_CYCLES(MUL_CYCLES)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model built on the simulator's native wide arithmetic.
   function automatic logic [63:0] ref_mul(input logic [1:0] op,
                                           input logic [63:0] a,
                                           input logic [63:0] b);
      logic signed [127:0] sa;
      logic signed [127:0] sb_;
      logic [127:0]        p;
      case (op)
         2'b00: p = {64'd0, a} * {64'd0, b};
         2'b01: begin
            sa  = {{64{a[63]}}, a};
            sb_ = {{64{b[63]}}, b};
            p   = sa * sb_;
         end
         2'b10: begin
            sa  = {{64{a[63]}}, a};
            sb_ = {64'd0, b};
            p   = sa * sb_;
         end
         default: p = {64'd0, a} * {64'd0, b};
      endcase
      return (op == 2'b00) ? p[63:0] : p[127:64];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive a request at a negedge. The request is taken on the following
   // posedge, and in_valid is then dropped.
   task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      sb.push_back(ref_mul(op, a, b));
      chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Count edges from the accept edge (counted as 1) until out_valid is seen.
   task automatic wait_result(output int lat);
      lat = 1;
      while (!out_valid && lat < TIMEOUT) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!out_valid) chk("timeout_out_valid", {63'd0, out_valid}, 64'd1);
   endtask

   task automatic check_result(input string tag, input logic [63:0] fixed_exp);
      logic [63:0] e;
      e = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
      chk({tag, "_model"}, out_result, e);
      chk({tag, "_const"}, out_result, fixed_exp);
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] fixed_exp, input int exp_lat);
      int lat;
      issue(op, a, b);
      wait_result(lat);
      check_result(tag, fixed_exp);
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      // out_ready is high, so the result retires on the next edge.
      @(posedge clk);
      #1;
      chk({tag, "_valid_one_cycle"}, {63'd0, out_valid}, 64'd0);
   endtask

   initial begin
      int lat;
      logic [63:0] held;
      int zlat;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_op     = 2'b00;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_out_result", out_result, 64'd0);
      chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      rst = 1'b0;

      // Directed cases from the plan
      run_op("mul_3x5", 2'b00, 64'd3, 64'd5, 64'h0000_0000_0000_000F, MUL_CYCLES + 1);
      run_op("mulh_m1x2", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
             64'hFFFF_FFFF_FFFF_FFFF, MUL_CYCLES + 1);
      run_op("mulhsu_m1x2", 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
             64'hFFFF_FFFF_FFFF_FFFF, MUL_CYCLES + 2);
      run_op("mulhu_max", 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFE, MUL_CYCLES + 1);
      run_op("mul_max", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h0000_0000_0000_0001, MUL_CYCLES + 1);
      // MULHSU with a positive a takes no FIX step
      run_op("mulhsu_pos", 2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h7FFF_FFFF_FFFF_FFFE, MUL_CYCLES + 1);
      // MULH negative x negative
      run_op("mulh_neg_neg", 2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
             64'h4000_0000_0000_0000, MUL_CYCLES + 1);
      // MULHSU with a negative a and b == 0 still takes FIX
`ifdef MUL64_ZERO_BYPASS_EN
      zlat = 1;
`else
      zlat = MUL_CYCLES + 2;
`endif
      run_op("mulhsu_b0", 2'b10, 64'h8000_0000_0000_0001, 64'd0, 64'd0, zlat);
      // mixed-sign MULH and MULHSU with non-trivial operands
      run_op("mulh_mix", 2'b01, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_0000_0000,
             64'hFFFF_FFFF_FFFF_FFFF, MUL_CYCLES + 1);
      run_op("mulhsu_mix", 2'b10, 64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000,
             64'hFFFF_FFFF_FFFF_FFFF, MUL_CYCLES + 2);

      // Backpressure: hold the result while a new request waits.
      out_ready = 1'b0;
      issue(2'b00, 64'd7, 64'd9);
      wait_result(lat);
      check_result("bp_first", 64'd63);
      held = out_result;
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = 2'b11;
      in_a     = 64'd100;
      in_b     = 64'd200;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_valid_held", {63'd0, out_valid}, 64'd1);
         chk("bp_result_held", out_result, held);
         chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      end
      sb.push_back(ref_mul(2'b11, 64'd100, 64'd200));
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_retire_valid", {63'd0, out_valid}, 64'd0);
      chk("bp_retire_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_new_accepted", {63'd0, in_ready}, 64'd0);
      wait_result(lat);
      check_result("bp_second", 64'd0);
      chk("bp_second_latency", 64'(lat), 64'(MUL_CYCLES + 1));
      @(posedge clk);
      #1;

      // Reset mid-CALC discards the operation.
      issue(2'b00, 64'd11, 64'd13);
      void'(sb.pop_back());
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      rst = 1'b0;
      repeat (MUL_CYCLES + 2) @(posedge clk);
      #1;
      chk("rst_discarded", {63'd0, out_valid}, 64'd0);
      run_op("mulhu_after_rst", 2'b11, 64'h0000_000F_FFFF_FFFF, 64'h0000_000F_FFFF_FFFF,
             64'h0000_0000_0000_00FF, MUL_CYCLES + 1);

      chk("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
